div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 13 +
 rtl/div_unit.sv | 118 +++++++++++
 tb/tb_div_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared CPU definitions for the iterative divider: state encoding and iteration count.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    localparam int unsigned DIV_ITERATIONS = 32;
    localparam int unsigned DIV_CNT_W      = 6;

endpackage

// File: rtl/div_unit.sv
// DIV/DIVU execution unit: restoring radix-2 divider, one quotient bit per cycle.
// Operands are captured as magnitudes (signed) or raw values (unsigned); the
// result signs are applied when the final iteration retires into DONE.
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        cancel,
    input  logic        advance,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(DIV_ITERATIONS - 1);

    div_state_t            r_state;
    div_state_t            w_state_next;
    logic [DIV_CNT_W-1:0]  r_cnt;
    logic [63:0]           r_pr;
    logic [31:0]           r_dvsr;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic [31:0]           r_quot;
    logic [31:0]           r_rem;

    logic                  w_last;
    logic [31:0]           w_dvd_mag;
    logic [31:0]           w_dvs_mag;
    logic [32:0]           w_hi;
    logic                  w_fits;
    logic [31:0]           w_sub;
    logic [63:0]           w_pr_next;
    logic [31:0]           w_q_fix;
    logic [31:0]           w_r_fix;

    assign w_last    = (r_cnt == LAST_CNT);
    assign w_dvd_mag = (is_signed && dividend[31]) ? (~dividend + 32'd1) : dividend;
    assign w_dvs_mag = (is_signed && divisor[31])  ? (~divisor + 32'd1)  : divisor;

    // The shifted-out bit 63 is kept as bit 32 of the trial value, so a
    // remainder near 2^32 still compares correctly against a large divisor.
    assign w_hi      = r_pr[63:31];
    assign w_fits    = (w_hi >= {1'b0, r_dvsr});
    assign w_sub     = r_pr[62:31] - r_dvsr;
    assign w_pr_next = w_fits ? {w_sub, r_pr[30:0], 1'b1} : {r_pr[62:0], 1'b0};

    assign w_q_fix   = r_neg_q ? (~w_pr_next[31:0] + 32'd1)  : w_pr_next[31:0];
    assign w_r_fix   = r_neg_r ? (~w_pr_next[63:32] + 32'd1) : w_pr_next[63:32];

    assign busy      = !rst && !cancel &&
                       (((r_state == DIV_IDLE) && start) || (r_state == DIV_RUN));
    assign done      = (r_state == DIV_DONE);
    assign quotient  = r_quot;
    assign remainder = r_rem;

    // Next-state selection; cancel overrides everything, DONE ignores start.
    always_comb begin
        w_state_next = r_state;
        if (cancel) begin
            w_state_next = DIV_IDLE;
        end else begin
            case (r_state)
                DIV_IDLE: if (start)   w_state_next = DIV_RUN;
                DIV_RUN:  if (w_last)  w_state_next = DIV_DONE;
                DIV_DONE: if (advance) w_state_next = DIV_IDLE;
                default:               w_state_next = DIV_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= DIV_IDLE;
        else     r_state <= w_state_next;
    end

    // Operand capture, iteration datapath and sign-corrected result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_pr    <= '0;
            r_dvsr  <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
        end else if (!cancel) begin
            case (r_state)
                DIV_IDLE: begin
                    if (start) begin
                        r_cnt   <= '0;
                        r_pr    <= {32'd0, w_dvd_mag};
                        r_dvsr  <= w_dvs_mag;
                        r_neg_q <= is_signed && (dividend[31] ^ divisor[31]);
                        r_neg_r <= is_signed && dividend[31];
                    end
                end
                DIV_RUN: begin
                    r_pr  <= w_pr_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_quot <= w_q_fix;
                        r_rem  <= w_r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, multi-cycle corner
// sequences (cancel, stall in DONE, reset mid-iteration) and random operands
// checked against plain-arithmetic division.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        advance;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_cmp  = 0;
    int n_fail = 0;

    div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .cancel    (cancel),
        .advance   (advance),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: native integer division (truncating, remainder follows dividend).
    function automatic void model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Issue one divide and wait (bounded) for done; returns cycles-to-done and busy count.
    task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input bit keep_start,
                          output logic [31:0] q, output logic [31:0] r,
                          output int lat, output int nbusy);
        @(negedge clk);
        start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
        lat = -1; nbusy = 0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (done) begin
                lat = c;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
            if (!keep_start) begin
                start = 1'b0;
                dividend = $urandom;
                divisor  = $urandom;
            end
        end
        q = quotient;
        r = remainder;
    endtask

    task automatic release_done(input string name);
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        #1;
        check({name, "_idle_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [31:0] q, r, eq, er;
        int lat, nb;

        tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        tbl[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
        tbl[2] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
        tbl[3] = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
        tbl[4] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF};
        tbl[5] = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0};
        tbl[6] = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5};
        tbl[7] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0};
        tbl[8] = '{1'b1, 32'd0,          32'hFFFFFFFB,   32'd0,          32'd0};
        tbl[9] = '{1'b0, 32'hFFFFFFFE,   32'h80000001,   32'd1,          32'h7FFFFFFD};

        rst = 1'b1; start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        cancel = 1'b0; advance = 1'b0;

        // Reset: busy suppressed even with start high, outputs cleared.
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quot", quotient, 32'd0);
        check("rst_rem",  remainder, 32'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            do_div(tbl[i].sgn, tbl[i].a, tbl[i].b, 1'b0, q, r, lat, nb);
            check($sformatf("vec%0d_lat", i),  lat, 32'd33);
            check($sformatf("vec%0d_busy", i), nb,  32'd33);
            check($sformatf("vec%0d_busy_done", i), {31'd0, busy}, 32'd0);
            check($sformatf("vec%0d_q", i), q, tbl[i].q);
            check($sformatf("vec%0d_r", i), r, tbl[i].r);
            release_done($sformatf("vec%0d", i));
        end

        // Divide by zero: normal timing, X-free results.
        do_div(1'b0, 32'd1234, 32'd0, 1'b0, q, r, lat, nb);
        check("div0_lat", lat, 32'd33);
        check("div0_xfree", {31'd0, $isunknown({q, r})}, 32'd0);
        release_done("div0");

        // Cancel has priority over start in IDLE.
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; dividend = 32'd50; divisor = 32'd5;
        #1;
        check("cancel_prio_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        #1;
        check("cancel_prio_idle", {31'd0, busy}, 32'd0);

        // Cancel at iteration 10 (cycle T+11).
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("cancel_pre_busy", {31'd0, busy}, 32'd1);
        cancel = 1'b1;
        #1;
        check("cancel_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        cancel = 1'b0;
        #1;
        check("cancel_idle_busy", {31'd0, busy}, 32'd0);
        check("cancel_idle_done", {31'd0, done}, 32'd0);
        do_div(1'b0, 32'd9, 32'd3, 1'b0, q, r, lat, nb);
        check("post_cancel_busy", nb, 32'd33);
        check("post_cancel_q", q, 32'd3);
        check("post_cancel_r", r, 32'd0);
        release_done("post_cancel");

        // Stall in DONE with start held: no restart, results stable.
        do_div(1'b0, 32'd1000, 32'd7, 1'b1, q, r, lat, nb);
        check("stall_lat", lat, 32'd33);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d_done", k), {31'd0, done}, 32'd1);
            check($sformatf("stall%0d_busy", k), {31'd0, busy}, 32'd0);
            check($sformatf("stall%0d_q", k), quotient, 32'd142);
            check($sformatf("stall%0d_r", k), remainder, 32'd6);
            @(negedge clk);
            #1;
        end
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        #1;
        check("stall_exit_done", {31'd0, done}, 32'd0);
        check("stall_exit_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("restart_from_idle", {31'd0, busy}, 32'd1);
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        #1;
        check("restart_cancel_busy", {31'd0, busy}, 32'd0);

        // Reset at iteration 20 (cycle T+21).
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd500; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("hold_q_outside_done", quotient, 32'd142);
        rst = 1'b1;
        #1;
        check("rst_mid_busy_now", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_quot", quotient, 32'd0);
        check("rst_mid_rem",  remainder, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);

        // Randomized operands against the arithmetic model.
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a, b;
            bit sgn;
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom;
            if ($urandom_range(0, 3) == 0) b = ~b + 32'd1;
            if (b == 32'd0) b = 32'd1;
            model(sgn, a, b, eq, er);
            do_div(sgn, a, b, 1'b0, q, r, lat, nb);
            check($sformatf("rnd%0d_lat", i), lat, 32'd33);
            check($sformatf("rnd%0d_q", i), q, eq);
            check($sformatf("rnd%0d_r", i), r, er);
            release_done($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
